// File: rtl/data_mem_stream_master_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// data_mem_stream_master_if : command, memory-port and stream bundle  (Rev 1.0)
// ----------------------------------------------------------------------------
interface data_mem_stream_master_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              start;
  logic              op;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] stride;
  logic [ADDR_W-1:0] count;
  logic              busy;
  logic              done;
  logic              err;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              mem_we;
  logic [DATA_W-1:0] mem_q;

  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_data;
  logic              i_valid;
  logic              i_ready;

  modport master (
    input  start, op, base_addr, stride, count, mem_q, o_ready, i_data, i_valid,
    output busy, done, err, mem_addr, mem_din, mem_we, o_data, o_valid, i_ready
  );

  modport slave (
    output start, op, base_addr, stride, count, mem_q, o_ready, i_data, i_valid,
    input  busy, done, err, mem_addr, mem_din, mem_we, o_data, o_valid, i_ready
  );
endinterface
`default_nettype wire

// File: rtl/data_mem_stream_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// data_mem_stream_master : strided burst mover between data memory and streams
// Rev 1.0
// ----------------------------------------------------------------------------
module data_mem_stream_master #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_DEPTH  = 1000,
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  data_mem_stream_master_if.master   bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;
  localparam logic [ADDR_W-1:0] c_MEM_DEPTH  = ADDR_W'(MEM_DEPTH);
  localparam logic [OCC_W-1:0]  c_FIFO_DEPTH = OCC_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] c_ONE        = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD       = 3'd1,
    S_RD_DRAIN = 3'd2,
    S_WR       = 3'd3,
    S_FIN      = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_stride;
  logic [ADDR_W-1:0]   r_remain;
  logic [ADDR_W-1:0]   r_last_addr;
  logic [DATA_W-1:0]   r_last_din;
  logic                r_err;
  logic                r_inflight;

  logic [DATA_W-1:0]   r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wptr;
  logic [PTR_W-1:0]    r_rptr;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_in_range;
  logic                w_last;
  logic [OCC_W-1:0]    w_occ;
  logic                w_space;
  logic                w_o_valid;
  logic                w_pop;
  logic                w_rd_issue;
  logic                w_wr_issue;
  logic                w_i_ready;
  logic                w_abort;

  assign w_in_range = (r_addr < c_MEM_DEPTH);
  assign w_last     = (r_remain == c_ONE);
  // A read in flight already owns a FIFO slot, so it counts toward occupancy.
  assign w_occ      = {1'b0, r_cnt} + OCC_W'(r_inflight);
  assign w_space    = (w_occ < c_FIFO_DEPTH);
  assign w_o_valid  = (r_cnt != '0);
  assign w_pop      = w_o_valid & bus.o_ready;

  always_comb begin
    w_next     = r_state;
    w_rd_issue = 1'b0;
    w_wr_issue = 1'b0;
    w_i_ready  = 1'b0;
    w_abort    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.count == '0) begin
            w_next = S_FIN;
          end else if (bus.op) begin
            w_next = S_WR;
          end else begin
            w_next = S_RD;
          end
        end
      end
      S_RD: begin
        if (!w_in_range) begin
          w_abort = 1'b1;
          w_next  = S_RD_DRAIN;
        end else if (w_space) begin
          w_rd_issue = 1'b1;
          if (w_last) begin
            w_next = S_RD_DRAIN;
          end
        end
      end
      S_RD_DRAIN: begin
        // Leave as the last word is popped so done lands one cycle after it.
        if (!r_inflight && ((r_cnt == '0) || ((r_cnt == CNT_W'(1)) && w_pop))) begin
          w_next = S_FIN;
        end
      end
      S_WR: begin
        if (!w_in_range) begin
          w_abort = 1'b1;
          w_next  = S_FIN;
        end else if (r_remain != '0) begin
          w_i_ready = 1'b1;
          if (bus.i_valid) begin
            w_wr_issue = 1'b1;
            if (w_last) begin
              w_next = S_FIN;
            end
          end
        end
      end
      S_FIN: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_stride    <= '0;
      r_remain    <= '0;
      r_last_addr <= '0;
      r_last_din  <= '0;
      r_err       <= 1'b0;
      r_inflight  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_inflight <= w_rd_issue;
      if ((r_state == S_IDLE) && bus.start) begin
        r_addr   <= bus.base_addr;
        r_stride <= bus.stride;
        r_remain <= bus.count;
        r_err    <= 1'b0;
      end
      if (w_rd_issue || w_wr_issue) begin
        r_addr      <= r_addr + r_stride;
        r_remain    <= r_remain - c_ONE;
        r_last_addr <= r_addr;
      end
      if (w_wr_issue) begin
        r_last_din <= bus.i_data;
      end
      if (w_abort) begin
        r_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (r_inflight) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({r_inflight, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage needs no reset: occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (r_inflight) begin
      r_fifo[r_wptr] <= bus.mem_q;
    end
  end

  assign bus.mem_addr = (w_rd_issue || w_wr_issue) ? r_addr : r_last_addr;
  assign bus.mem_din  = w_wr_issue ? bus.i_data : r_last_din;
  assign bus.mem_we   = w_wr_issue;
  assign bus.busy     = (r_state == S_RD) || (r_state == S_RD_DRAIN) || (r_state == S_WR);
  assign bus.done     = (r_state == S_FIN);
  assign bus.err      = (r_state == S_FIN) && r_err;
  assign bus.o_valid  = w_o_valid;
  assign bus.o_data   = r_fifo[r_rptr];
  assign bus.i_ready  = w_i_ready;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_stream_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_data_mem_stream_master : directed and random bursts against a memory model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_data_mem_stream_master;

  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int DEPTH = 1000;
  localparam int FD    = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_mem_stream_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  data_mem_stream_master #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH), .FIFO_DEPTH(FD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Write-first synchronous memory.
  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] q_r;
  assign bus.mem_q = q_r;

  always @(posedge clk) begin
    if (bus.mem_addr < AW'(DEPTH)) begin
      if (bus.mem_we) begin
        ram[int'(bus.mem_addr)] <= bus.mem_din;
        q_r <= bus.mem_din;
      end else begin
        q_r <= ram[int'(bus.mem_addr)];
      end
    end else begin
      q_r <= 16'hDEAD;
    end
  end

  int oob_cnt = 0;
  always @(negedge clk) begin
    if (!rst && (bus.mem_addr >= AW'(DEPTH))) oob_cnt++;
  end

  logic [DW-1:0] exp_mem [DEPTH];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus.start     = 1'b0;
    bus.op        = 1'b0;
    bus.base_addr = '0;
    bus.stride    = '0;
    bus.count     = '0;
    bus.o_ready   = 1'b0;
    bus.i_valid   = 1'b0;
    bus.i_data    = '0;
  endtask

  // rdy_mode: 0 = always ready, 1 = random, 2 = low for the first 6 cycles
  task automatic run_burst(input string name, input bit op, input int base,
                           input int stride, input int cnt, input int rdy_mode,
                           input bit poke, input bit fixed_wdata);
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];
    logic [DW-1:0] wdata[$];
    int            waddr[$];
    bit            exp_err = 1'b0;
    bit            got_done = 1'b0;
    bit            got_err = 1'b0;
    bit            stall = 1'b0;
    logic [DW-1:0] stall_data = '0;
    int a, n, wr_idx = 0, cyc = 0, done_cyc = -1, first_v = -1, last_hs = -1, we_seen = 0;

    for (int i = 0; i < cnt; i++) begin
      a = (base + i * stride) & 16'hFFFF;
      if (a >= DEPTH) begin
        exp_err = 1'b1;
        break;
      end
      if (op) begin
        wdata.push_back(fixed_wdata ? 16'(16'hAAAA + i * 16'h1111) : 16'($urandom));
        waddr.push_back(a);
      end else begin
        exp_q.push_back(exp_mem[a]);
      end
    end

    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = op; bus.base_addr = AW'(base);
    bus.stride = AW'(stride); bus.count = AW'(cnt);
    @(posedge clk); #1;
    bus.start = 1'b0;

    while (!got_done && cyc < 300) begin
      case (rdy_mode)
        0:       bus.o_ready = 1'b1;
        1:       bus.o_ready = ($urandom_range(0, 3) != 0);
        default: bus.o_ready = (cyc >= 6);
      endcase
      bus.i_valid = op && ($urandom_range(0, 2) != 0);
      bus.i_data  = (wr_idx < wdata.size()) ? wdata[wr_idx] : 16'($urandom);
      bus.start   = poke && (cyc == 1);
      if (poke) begin
        bus.op = ~op; bus.base_addr = '0; bus.count = AW'(5);
      end
      @(negedge clk);
      if (cyc == 0 && cnt != 0) chk({name, " busy"}, 32'(bus.busy), 32'd1);
      if (stall) chk({name, " hold"}, {15'd0, bus.o_valid, bus.o_data}, {15'd0, 1'b1, stall_data});
      stall = bus.o_valid && !bus.o_ready;
      stall_data = bus.o_data;
      if (bus.mem_we) we_seen++;
      if (bus.o_valid && first_v < 0) first_v = cyc;
      if (bus.o_valid && bus.o_ready) begin
        got_q.push_back(bus.o_data);
        last_hs = cyc;
      end
      if (bus.i_valid && bus.i_ready) begin
        if (wr_idx < waddr.size()) begin
          chk({name, " wr_we"}, 32'(bus.mem_we), 32'd1);
          chk({name, " wr_addr"}, 32'(bus.mem_addr), 32'(waddr[wr_idx]));
          chk({name, " wr_din"}, 32'(bus.mem_din), 32'(wdata[wr_idx]));
        end
        wr_idx++;
        last_hs = cyc;
      end
      // With the consumer stalled, exactly FD reads go out and issue stops.
      if (rdy_mode == 2 && cyc == 5 && !exp_err && cnt >= FD) begin
        chk({name, " stall_addr"}, 32'(bus.mem_addr), 32'((base + (FD - 1) * stride) & 16'hFFFF));
        chk({name, " stall_valid"}, 32'(bus.o_valid), 32'd1);
      end
      if (bus.done) begin
        got_done = 1'b1;
        got_err  = bus.err;
        done_cyc = cyc;
        chk({name, " busy_at_done"}, 32'(bus.busy), 32'd0);
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0; bus.o_ready = 1'b0; bus.i_valid = 1'b0;

    chk({name, " done_seen"}, 32'(got_done), 32'd1);
    chk({name, " err"}, 32'(got_err), 32'(exp_err));
    chk({name, " rd_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({name, " rd_data"}, 32'(got_q[i]), 32'(exp_q[i]));
    chk({name, " wr_count"}, 32'(wr_idx), 32'(waddr.size()));
    chk({name, " we_cycles"}, 32'(we_seen), 32'(waddr.size()));
    for (int i = 0; i < waddr.size(); i++) exp_mem[waddr[i]] = wdata[i];
    for (int i = 0; i < waddr.size(); i++) chk({name, " ram"}, 32'(ram[waddr[i]]), 32'(exp_mem[waddr[i]]));

    if (cnt == 0) chk({name, " done_lat0"}, 32'(done_cyc), 32'd0);
    // First issue in the cycle after accept, data one cycle later, FIFO the next.
    if (!op && rdy_mode == 0 && exp_q.size() > 0) chk({name, " first_valid"}, 32'(first_v), 32'd2);
    if (!op && exp_q.size() > 0) chk({name, " done_after_last"}, 32'(done_cyc), 32'(last_hs + 1));
    if (op && !exp_err && waddr.size() > 0) chk({name, " done_after_wr"}, 32'(done_cyc), 32'(last_hs + 1));
  endtask

  initial begin
    int rb, rs, rc, ro;
    for (int k = 0; k < DEPTH; k++) begin
      ram[k] <= 16'(k + 16'h100);
      exp_mem[k] = 16'(k + 16'h100);
    end
    drive_idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst done", 32'(bus.done), 32'd0);
    chk("rst err", 32'(bus.err), 32'd0);
    chk("rst mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst o_valid", 32'(bus.o_valid), 32'd0);
    chk("rst i_ready", 32'(bus.i_ready), 32'd0);
    chk("rst mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst mem_din", 32'(bus.mem_din), 32'd0);
    rst = 1'b0;

    run_burst("rd_basic", 1'b0, 10, 1, 4, 0, 1'b0, 1'b0);
    run_burst("rd_stall", 1'b0, 10, 1, 4, 2, 1'b0, 1'b0);
    run_burst("rd_stall6", 1'b0, 40, 2, 6, 2, 1'b0, 1'b0);
    run_burst("wr_gap", 1'b1, 100, 3, 3, 1, 1'b0, 1'b1);
    chk("wr_gap ram100", 32'(ram[100]), 32'h0000AAAA);
    chk("wr_gap ram103", 32'(ram[103]), 32'h0000BBBB);
    chk("wr_gap ram106", 32'(ram[106]), 32'h0000CCCC);
    run_burst("rd_edge", 1'b0, 998, 1, 4, 0, 1'b0, 1'b0);
    run_burst("cnt0", 1'b0, 50, 1, 0, 0, 1'b0, 1'b0);
    run_burst("poke", 1'b0, 200, 1, 3, 0, 1'b1, 1'b0);

    // Reset while the second element of an 8-word read is on the stream.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 1'b0; bus.base_addr = AW'(20);
    bus.stride = AW'(1); bus.count = AW'(8);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.o_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid second_elem", 32'(bus.o_data), 32'(exp_mem[21]));
    rst = 1'b1;
    #1;
    chk("mid busy", 32'(bus.busy), 32'd0);
    chk("mid o_valid", 32'(bus.o_valid), 32'd0);
    chk("mid mem_we", 32'(bus.mem_we), 32'd0);
    chk("mid done", 32'(bus.done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.o_ready = 1'b0;
    @(negedge clk);
    chk("post_rst done", 32'(bus.done), 32'd0);
    chk("post_rst busy", 32'(bus.busy), 32'd0);
    run_burst("after_rst", 1'b0, 0, 1, 2, 0, 1'b0, 1'b0);

    for (int t = 0; t < 25; t++) begin
      ro = $urandom_range(0, 1);
      rb = ($urandom_range(0, 1) != 0) ? $urandom_range(0, DEPTH - 1) : $urandom_range(990, 1005);
      rs = $urandom_range(0, 5);
      rc = $urandom_range(0, 8);
      run_burst("rand", ro[0], rb, rs, rc, $urandom_range(0, 1), 1'b0, 1'b0);
    end

    chk("no_oob_access", 32'(oob_cnt), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
